alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the single-cycle ALU. It accepts one 32-bit instruction through a valid/ready handshake and reads the operands from the external register file. It then drives the ALU's I1/I2/Selector inputs, captures the result and writes it back. It sits between the instruction source and the ALU/register-file pair.

---
 rtl/alu_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Multi-cycle issue controller for a single-cycle ALU. It accepts one
// 32-bit instruction over a valid/ready handshake and reads rs/rt from an
// external register file, which has one cycle of read latency. It then
// drives the ALU operands and selector, captures the ALU result, and writes
// that result back to rd. An instruction occupies the controller for four
// cycles: IDLE -> READ -> EXEC -> WB.
//
// Instruction format:
//   op = instr[31:27], rd = instr[26:22], rs = instr[21:17],
//   rt = instr[16:12], imm = instr[15:0] (zero-extended)
// Legal ops: 2 NOT (rs, 0), 7 NORI (rs, imm), 16 ADD (rs, rt), 19 NOR (rs, rt).
//
// Ports:
//   clk, reset               single rising-edge clock, synchronous active-high reset
//   instr, instr_valid       instruction source; transfers when valid & ready
//   instr_ready              high only while IDLE
//   rf_ra1, rf_ra2           register-file read addresses (rs, rt); held between uses
//   rf_rd1, rf_rd2           register-file read data, valid one cycle after address
//   rf_we, rf_wa, rf_wd      register-file write port (WB only; wa/wd zero when idle)
//   alu_i1, alu_i2, alu_sel  ALU operands and selector (non-zero only in EXEC)
//   alu_o                    ALU result, captured at the end of EXEC
//   done, illegal            one-cycle retire pulse; illegal flags an unsupported op
//   retired                  wrapping count of retired instructions, illegal ones included

module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] alu_i1,
    output logic [DATA_W-1:0] alu_i2,
    output logic [4:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_o,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam logic [4:0] OP_NOT  = 5'd2;
    localparam logic [4:0] OP_NORI = 5'd7;
    localparam logic [4:0] OP_ADD  = 5'd16;
    localparam logic [4:0] OP_NOR  = 5'd19;

    state_e              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [REG_AW-1:0]   ra1_q, ra1_d;
    logic [REG_AW-1:0]   ra2_q, ra2_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    // Fields of the latched instruction.
    logic [4:0]          op;
    logic [4:0]          rd;
    logic [DATA_W-1:0]   imm_ext;
    logic                legal;
    logic                wr_en;

    assign op      = instr_q[31:27];
    assign rd      = instr_q[26:22];
    assign imm_ext = DATA_W'(instr_q[15:0]);
    assign legal   = (op == OP_NOT) || (op == OP_NORI) ||
                     (op == OP_ADD) || (op == OP_NOR);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        instr_d   = instr_q;
        ra1_d     = ra1_q;
        ra2_d     = ra2_q;
        result_d  = result_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    state_d = S_READ;
                    instr_d = instr;
                    // Loading the read addresses at acceptance makes them
                    // valid throughout READ and lets them hold afterwards.
                    ra1_d   = REG_AW'(instr[21:17]);
                    ra2_d   = REG_AW'(instr[16:12]);
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                state_d   = S_WB;
                result_d  = alu_o;
                // Counting on entry to WB makes retired already show the new
                // value in the same cycle that done pulses.
                retired_d = retired_q + CNT_W'(1);
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here, so every flop samples the
        // values from before the edge regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            result_q  <= result_d;
            retired_q <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register and the latched instruction.
    // The write strobe comes from the state, so a reset edge that leaves WB
    // or EXEC kills any pending write.
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        rf_ra1      = ra1_q;
        rf_ra2      = ra2_q;
        retired     = retired_q;

        alu_sel = '0;
        alu_i1  = '0;
        alu_i2  = '0;
        if (state_q == S_EXEC && legal) begin
            alu_sel = op;
            alu_i1  = rf_rd1;
            case (op)
                OP_NORI:        alu_i2 = imm_ext;
                OP_ADD, OP_NOR: alu_i2 = rf_rd2;
                default:        alu_i2 = '0;
            endcase
        end

        done    = (state_q == S_WB);
        illegal = (state_q == S_WB) && !legal;
        wr_en   = (state_q == S_WB) && legal && (rd != 5'd0);
        rf_we   = wr_en;
        rf_wa   = wr_en ? REG_AW'(rd) : '0;
        rf_wd   = wr_en ? result_q    : '0;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. The bench supplies the environment: a
// register file with one cycle of read latency and a combinational ALU. A
// table of directed vectors runs first, followed by hand-written
// back-to-back and reset sequences. Random instructions are then checked
// against a shadow register file and an instruction-level reference model.

module tb_alu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;   // small, so that the counter wrap is exercised

    logic              clk;
    logic              reset;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [REG_AW-1:0] rf_ra1, rf_ra2;
    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [DATA_W-1:0] alu_i1, alu_i2;
    logic [4:0]        alu_sel;
    logic [DATA_W-1:0] alu_o;
    logic              done, illegal;
    logic [CNT_W-1:0]  retired;

    alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_o(alu_o),
        .done(done), .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: register file and ALU ----------------
    logic [31:0] rf_mem [32];
    logic        pre_we;
    logic [4:0]  pre_a1, pre_a2;
    logic [31:0] pre_d1, pre_d2;

    always @(posedge clk) begin
        rf_rd1 <= rf_mem[rf_ra1];
        rf_rd2 <= rf_mem[rf_ra2];
        if (pre_we) begin
            rf_mem[pre_a1] <= pre_d1;
            rf_mem[pre_a2] <= pre_d2;
        end
        if (rf_we) rf_mem[rf_wa] <= rf_wd;
    end

    always_comb begin
        alu_o = '0;
        case (alu_sel)
            5'd2:  alu_o = ~alu_i1;
            5'd7:  alu_o = ~(alu_i1 | alu_i2);
            5'd16: alu_o = alu_i1 + alu_i2;
            5'd19: alu_o = ~(alu_i1 | alu_i2);
            default: alu_o = '0;
        endcase
    end

    // ---------------- scoreboard state ----------------
    int          n_vec;
    int          n_err;
    int          exp_ret;
    logic [31:0] model_rf [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: what the ALU should see and what should
    // be written back, given the operand values held in the register file.
    function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [4:0] sel, output logic [31:0] i1,
                                      output logic [31:0] i2, output logic we,
                                      output logic ill, output logic [4:0] wa,
                                      output logic [31:0] wd);
        logic [4:0]  op;
        logic [31:0] imm;
        logic [31:0] res;
        op  = ins[31:27];
        imm = {16'h0000, ins[15:0]};
        sel = op; i1 = a; i2 = 32'h0; res = 32'h0; ill = 1'b0;
        case (op)
            5'd2:  res = ~a;
            5'd7:  begin i2 = imm; res = ~(a | imm); end
            5'd16: begin i2 = b;   res = a + b;      end
            5'd19: begin i2 = b;   res = ~(a | b);   end
            default: begin ill = 1'b1; sel = 5'd0; i1 = 32'h0; end
        endcase
        we = !ill && (ins[26:22] != 5'd0);
        wa = we ? ins[26:22] : 5'd0;
        wd = we ? res : 32'h0;
    endfunction

    // Write two registers of the environment RF (and the shadow copy).
    task automatic preload(input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2);
        pre_we = 1'b1; pre_a1 = a1; pre_d1 = d1; pre_a2 = a2; pre_d2 = d2;
        @(negedge clk);
        pre_we = 1'b0;
        model_rf[a1] = d1;
        model_rf[a2] = d2;
    endtask

    // Issue one instruction from an idle controller and check every cycle up
    // to the next idle cycle. Garbage is driven on instr, with valid high,
    // while the controller is busy. Called and returns on a falling edge.
    task automatic issue(input logic [31:0] ins, input logic [4:0] e_sel,
                         input logic [31:0] e_i1, input logic [31:0] e_i2,
                         input logic e_we, input logic e_ill,
                         input logic [4:0] e_wa, input logic [31:0] e_wd);
        check("ready_idle", 32'(instr_ready), 1);
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);                                   // T+1: READ
        instr = $urandom;
        check("ready_read", 32'(instr_ready), 0);
        check("ra1_read", 32'(rf_ra1), 32'(ins[21:17]));
        check("ra2_read", 32'(rf_ra2), 32'(ins[16:12]));
        check("sel_read", 32'(alu_sel), 0);
        check("done_read", 32'(done), 0);
        @(negedge clk);                                   // T+2: EXEC
        check("ready_exec", 32'(instr_ready), 0);
        check("alu_sel", 32'(alu_sel), 32'(e_sel));
        check("alu_i1", alu_i1, e_i1);
        check("alu_i2", alu_i2, e_i2);
        check("we_exec", 32'(rf_we), 0);
        @(negedge clk);                                   // T+3: WB
        instr_valid = 1'b0;
        exp_ret++;
        check("done_wb", 32'(done), 1);
        check("illegal_wb", 32'(illegal), 32'(e_ill));
        check("rf_we", 32'(rf_we), 32'(e_we));
        check("rf_wa", 32'(rf_wa), 32'(e_wa));
        check("rf_wd", rf_wd, e_wd);
        check("retired", 32'(retired), 32'(exp_ret % (1 << CNT_W)));
        check("alu_i1_wb", alu_i1, 0);
        @(negedge clk);                                   // T+4: IDLE again
        check("ready_next", 32'(instr_ready), 1);
        check("done_next", 32'(done), 0);
        check("we_next", 32'(rf_we), 0);
        check("ra1_hold", 32'(rf_ra1), 32'(ins[21:17]));
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  sel;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        we;
        logic        ill;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [4:0]  m_sel, m_wa, op;
        logic [31:0] m_i1, m_i2, m_wd, ins;
        logic        m_we, m_ill;

        n_vec = 0; n_err = 0; exp_ret = 0;
        reset = 1'b1; instr_valid = 1'b1; instr = {5'd16, 5'd3, 5'd1, 5'd2, 12'd0};
        pre_we = 1'b0; pre_a1 = '0; pre_a2 = '0; pre_d1 = '0; pre_d2 = '0;

        //         instr                               rs_val        rt_val        sel    i1            i2            we ill wa     wd
        vecs[0] = '{{5'd16, 5'd3, 5'd1, 5'd2, 12'd0},  32'd5,        32'd7,        5'd16, 32'd5,        32'd7,        1, 0, 5'd3,  32'd12};
        vecs[1] = '{{5'd7, 5'd5, 5'd4, 1'b0, 16'h00F0}, 32'h0000FF00, 32'h0,       5'd7,  32'h0000FF00, 32'h000000F0, 1, 0, 5'd5,  32'hFFFF000F};
        vecs[2] = '{{5'd2, 5'd0, 5'd1, 5'd0, 12'd0},   32'h0,        32'h0,        5'd2,  32'h0,        32'h0,        0, 0, 5'd0,  32'h0};
        vecs[3] = '{{5'd9, 5'd6, 5'd1, 5'd2, 12'd0},   32'h1234,     32'h5678,     5'd0,  32'h0,        32'h0,        0, 1, 5'd0,  32'h0};
        vecs[4] = '{{5'd19, 5'd7, 5'd8, 5'd9, 12'd0},  32'hF0F00000, 32'h00000F0F, 5'd19, 32'hF0F00000, 32'h00000F0F, 1, 0, 5'd7,  32'h0F0FF0F0};
        vecs[5] = '{{5'd16, 5'd31, 5'd30, 5'd29, 12'd0}, 32'hFFFFFFFF, 32'd2,      5'd16, 32'hFFFFFFFF, 32'd2,        1, 0, 5'd31, 32'd1};
        vecs[6] = '{{5'd2, 5'd10, 5'd11, 5'd12, 12'd0}, 32'h000000FF, 32'h5555,    5'd2,  32'h000000FF, 32'h0,        1, 0, 5'd10, 32'hFFFFFF00};
        vecs[7] = '{{5'd31, 5'd1, 5'd1, 5'd1, 12'd0},  32'hAAAA,     32'hAAAA,     5'd0,  32'h0,        32'h0,        0, 1, 5'd0,  32'h0};
        vecs[8] = '{{5'd16, 5'd2, 5'd6, 5'd6, 12'd0},  32'h40,       32'h40,       5'd16, 32'h40,       32'h40,       1, 0, 5'd2,  32'h80};

        // Reset with valid held high: nothing may be accepted.
        repeat (3) @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        check("rst_ready", 32'(instr_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_we", 32'(rf_we), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_ra1", 32'(rf_ra1), 0);
        check("rst_ra2", 32'(rf_ra2), 0);
        check("rst_wd", rf_wd, 0);
        check("rst_sel", 32'(alu_sel), 0);

        for (int i = 0; i < 16; i++)
            preload(5'(2 * i), $urandom, 5'(2 * i + 1), $urandom);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            preload(vecs[i].instr[21:17], vecs[i].rs_val, vecs[i].instr[16:12], vecs[i].rt_val);
            issue(vecs[i].instr, vecs[i].sel, vecs[i].i1, vecs[i].i2,
                  vecs[i].we, vecs[i].ill, vecs[i].wa, vecs[i].wd);
            if (vecs[i].we) model_rf[vecs[i].wa] = vecs[i].wd;
        end

        // Back-to-back with valid held high: r3 = r1 + r2, then r4 = r3 + r1.
        preload(5'd1, 32'd5, 5'd2, 32'd7);
        instr = {5'd16, 5'd3, 5'd1, 5'd2, 12'd0}; instr_valid = 1'b1;
        @(negedge clk);                                   // T+1
        instr = {5'd16, 5'd4, 5'd3, 5'd1, 12'd0};
        check("b2b_ready_t1", 32'(instr_ready), 0);
        @(negedge clk);                                   // T+2
        check("b2b_ready_t2", 32'(instr_ready), 0);
        @(negedge clk);                                   // T+3
        check("b2b_ready_t3", 32'(instr_ready), 0);
        check("b2b_done_t3", 32'(done), 1);
        check("b2b_wd_t3", rf_wd, 32'd12);
        @(negedge clk);                                   // T+4: second accepted at this edge
        check("b2b_ready_t4", 32'(instr_ready), 1);
        check("b2b_done_t4", 32'(done), 0);
        @(negedge clk);                                   // T+5
        instr_valid = 1'b0;
        check("b2b_ready_t5", 32'(instr_ready), 0);
        check("b2b_ra1_t5", 32'(rf_ra1), 3);
        @(negedge clk);                                   // T+6
        check("b2b_done_t6", 32'(done), 0);
        check("b2b_i1_t6", alu_i1, 32'd12);
        @(negedge clk);                                   // T+7
        exp_ret += 2;
        check("b2b_done_t7", 32'(done), 1);
        check("b2b_wa_t7", 32'(rf_wa), 4);
        check("b2b_wd_t7", rf_wd, 32'd17);
        check("b2b_retired", 32'(retired), 32'(exp_ret % (1 << CNT_W)));
        @(negedge clk);
        model_rf[3] = 32'd12;
        model_rf[4] = 32'd17;

        // Reset during EXEC of an ADD to r3: no write, counter cleared.
        preload(5'd3, 32'h3333, 5'd1, 32'd5);
        preload(5'd2, 32'd7, 5'd2, 32'd7);
        instr = {5'd16, 5'd3, 5'd1, 5'd2, 12'd0}; instr_valid = 1'b1;
        @(negedge clk);                                   // T+1
        instr_valid = 1'b0;
        @(negedge clk);                                   // T+2: EXEC
        check("rst_exec_sel", 32'(alu_sel), 16);
        reset = 1'b1;
        @(negedge clk);                                   // T+3
        reset = 1'b0;
        exp_ret = 0;
        check("rst_exec_we", 32'(rf_we), 0);
        check("rst_exec_done", 32'(done), 0);
        check("rst_exec_ready", 32'(instr_ready), 1);
        check("rst_exec_retired", 32'(retired), 0);
        check("rst_exec_ra1", 32'(rf_ra1), 0);
        @(negedge clk);
        check("rst_exec_r3", rf_mem[3], 32'h3333);
        issue({5'd16, 5'd3, 5'd1, 5'd2, 12'd0}, 5'd16, 32'd5, 32'd7, 1'b1, 1'b0, 5'd3, 32'd12);
        model_rf[3] = 32'd12;

        // Random instructions against the shadow register file.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 5'd2;
                1: op = 5'd7;
                2: op = 5'd16;
                3: op = 5'd19;
                default: begin
                    op = 5'($urandom);
                    while (op == 5'd2 || op == 5'd7 || op == 5'd16 || op == 5'd19)
                        op = 5'($urandom);
                end
            endcase
            ins = {op, 27'($urandom)};
            ref_model(ins, model_rf[ins[21:17]], model_rf[ins[16:12]],
                      m_sel, m_i1, m_i2, m_we, m_ill, m_wa, m_wd);
            issue(ins, m_sel, m_i1, m_i2, m_we, m_ill, m_wa, m_wd);
            if (m_we) model_rf[m_wa] = m_wd;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
